// File: rtl/control_seguimiento_pkg.sv
// Shared codes for the two-axis tracker: motor commands, modes, FSM states, axis indices.
package control_seguimiento_pkg;
  localparam logic [1:0] MOV_STOP = 2'b00;
  localparam logic [1:0] MOV_CW   = 2'b01;
  localparam logic [1:0] MOV_CCW  = 2'b11;

  localparam logic [1:0] MODE_AUTO = 2'b00;
  localparam logic [1:0] MODE_MAN  = 2'b01;

  localparam logic [2:0] S_TETA  = 3'd0;
  localparam logic [2:0] S_SET_T = 3'd1;
  localparam logic [2:0] S_FI    = 3'd2;
  localparam logic [2:0] S_SET_F = 3'd3;
  localparam logic [2:0] S_MAN   = 3'd4;
  localparam logic [2:0] S_PARK  = 3'd5;
  localparam logic [2:0] S_FAULT = 3'd6;

  localparam int NUM_AX  = 2;
  localparam int AX_TETA = 0;
  localparam int AX_FI   = 1;
endpackage

// File: rtl/control_seguimiento_param_eje.sv
// Per-axis combinational decision: band check, direction request, soft-limit gating.
module eje_comparador
  import control_seguimiento_pkg::*;
#(
  parameter int          DATA_W   = 16,
  parameter int          DEADBAND = 5,
  parameter int          MAN_TOL  = 2,
  parameter int unsigned POS_MIN  = 0,
  parameter int unsigned POS_MAX  = 2**DATA_W-1
)(
  input  logic              manual,
  input  logic [DATA_W-1:0] r1,
  input  logic [DATA_W-1:0] r2,
  input  logic [DATA_W-1:0] tgt,
  input  logic [DATA_W-1:0] act,
  output logic [1:0]        req,
  output logic              blocked,
  output logic              done
);
  localparam logic [DATA_W-1:0] PMIN  = DATA_W'(POS_MIN);
  localparam logic [DATA_W-1:0] PMAX  = DATA_W'(POS_MAX);
  localparam logic [DATA_W:0]   DBAND = (DATA_W+1)'(DEADBAND);
  localparam logic [DATA_W:0]   MBAND = (DATA_W+1)'(MAN_TOL);

  logic [DATA_W-1:0] tgt_lo, tgt_c, a, b;
  logic [DATA_W:0]   mag, band;
  logic [1:0]        dir;

  // Clamp only exists when the limit is inside the representable range.
  if (POS_MIN > 0) begin : g_clo
    assign tgt_lo = (tgt < PMIN) ? PMIN : tgt;
  end else begin : g_nlo
    assign tgt_lo = tgt;
  end
  if (POS_MAX < 2**DATA_W-1) begin : g_chi
    assign tgt_c = (tgt_lo > PMAX) ? PMAX : tgt_lo;
  end else begin : g_nhi
    assign tgt_c = tgt_lo;
  end

  always_comb begin
    a       = manual ? tgt_c : r1;
    b       = manual ? act   : r2;
    band    = manual ? MBAND : DBAND;
    mag     = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    dir     = (mag <= band) ? MOV_STOP : ((a > b) ? MOV_CW : MOV_CCW);
    blocked = ((dir == MOV_CW) && (act >= PMAX)) || ((dir == MOV_CCW) && (act <= PMIN));
    req     = blocked ? MOV_STOP : dir;
    done    = (req == MOV_STOP);
  end
endmodule

// File: rtl/control_seguimiento_param.sv
// Two-axis sun tracker: auto mode alternates axes with settle/timeout, manual drives both.
module control_seguimiento_param
  import control_seguimiento_pkg::*;
#(
  parameter int          DATA_W      = 16,
  parameter int          DEADBAND    = 5,
  parameter int          MAN_TOL     = 2,
  parameter int unsigned POS_MIN     = 0,
  parameter int unsigned POS_MAX     = 2**DATA_W-1,
  parameter int unsigned SETTLE_CYC  = 1000,
  parameter int unsigned TIMEOUT_CYC = 10**6
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        s,
  input  logic [DATA_W-1:0] R_vertical_1,
  input  logic [DATA_W-1:0] R_vertical_2,
  input  logic [DATA_W-1:0] R_horizontal_1,
  input  logic [DATA_W-1:0] R_horizontal_2,
  input  logic [DATA_W-1:0] teta_manual,
  input  logic [DATA_W-1:0] fi_manual,
  input  logic [DATA_W-1:0] teta_actual,
  input  logic [DATA_W-1:0] fi_actual,
  output logic [1:0]        s_out_teta,
  output logic [1:0]        s_out_fi,
  output logic              busy,
  output logic              at_limit,
  output logic              fault
);
  localparam int unsigned   CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int            CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] ST_LAST = CW'(SETTLE_CYC - 1);

  logic [NUM_AX-1:0][DATA_W-1:0] r1, r2, tgt, act;
  logic [NUM_AX-1:0][1:0]        req, cmd_d, cmd_g, cmd_q;
  logic [NUM_AX-1:0]             blocked, done;
  logic [2:0]                    st_d, st_q;
  logic [CW-1:0]                 cnt_d, cnt_q;
  logic                          manual, ax, lim_d, lim_q, fault_d, fault_q;

  assign r1     = {R_horizontal_1, R_vertical_1};
  assign r2     = {R_horizontal_2, R_vertical_2};
  assign tgt    = {fi_manual, teta_manual};
  assign act    = {fi_actual, teta_actual};
  assign manual = (s == MODE_MAN);

  for (genvar g = 0; g < NUM_AX; g++) begin : g_ax
    eje_comparador #(
      .DATA_W(DATA_W), .DEADBAND(DEADBAND), .MAN_TOL(MAN_TOL),
      .POS_MIN(POS_MIN), .POS_MAX(POS_MAX)
    ) u_eje (
      .manual(manual), .r1(r1[g]), .r2(r2[g]), .tgt(tgt[g]), .act(act[g]),
      .req(req[g]), .blocked(blocked[g]), .done(done[g])
    );
  end

  // Mode is decided first; any state change clears the shared timer.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    lim_d   = 1'b0;
    cmd_d   = '0;
    ax      = (st_q == S_FI);
    if (s[1]) begin
      st_d = S_PARK; cnt_d = '0; fault_d = 1'b0;
    end else if (manual) begin
      st_d = S_MAN; cnt_d = '0; fault_d = 1'b0;
      if (st_q == S_MAN) begin
        cmd_d = req;
        lim_d = |blocked;
      end
    end else begin
      case (st_q)
        S_TETA, S_FI: begin
          if (done[ax]) begin
            st_d  = ax ? S_SET_F : S_SET_T;
            cnt_d = '0;
            lim_d = blocked[ax];
          end else if (cnt_q >= TO_LAST) begin
            st_d = S_FAULT; cnt_d = '0; fault_d = 1'b1;
          end else begin
            cmd_d[ax] = req[ax];
            cnt_d     = cnt_q + 1'b1;
          end
        end
        S_SET_T, S_SET_F: begin
          if (cnt_q >= ST_LAST) begin
            st_d  = (st_q == S_SET_T) ? S_FI : S_TETA;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_FAULT: fault_d = 1'b1;
        default: begin st_d = S_TETA; cnt_d = '0; end
      endcase
    end
  end

  // A direct cw<->ccw swap is replaced by one stop cycle.
  always_comb begin
    cmd_g = cmd_d;
    for (int i = 0; i < NUM_AX; i++)
      if (cmd_q[i][0] && cmd_d[i][0] && (cmd_q[i][1] != cmd_d[i][1])) cmd_g[i] = MOV_STOP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= S_TETA;
      cnt_q   <= '0;
      cmd_q   <= '0;
      lim_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_g;
      lim_q   <= lim_d;
      fault_q <= fault_d;
    end
  end

  assign s_out_teta = cmd_q[AX_TETA];
  assign s_out_fi   = cmd_q[AX_FI];
  assign busy       = (cmd_q[AX_TETA] != MOV_STOP) || (cmd_q[AX_FI] != MOV_STOP);
  assign at_limit   = lim_q;
  assign fault      = fault_q;
endmodule
